// File: rtl/my_ram_pkg.sv
// Shared types and default geometry for the my_ram_n word store and its
// zero-sweep controller.
package my_ram_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DEPTH = 64;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/my_ram_clear_fsm.sv
// Zero-sweep controller: walks a pointer across every word while CLEAR is
// active and hands the storage a write enable plus address for each step.
module my_ram_clear_fsm
    import my_ram_pkg::*;
#(
    parameter  int DEPTH  = DEFAULT_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    output logic              busy,
    output logic              clear_we,
    output logic [ADDR_W-1:0] clear_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] ptr;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr) begin
                        state <= CLEAR;
                        ptr   <= '0;
                    end
                end
                CLEAR: begin
                    // ptr wraps to 0 naturally on the final word.
                    ptr <= ptr + ADDR_W'(1);
                    if (ptr == LAST_ADDR) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    ptr   <= '0;
                end
            endcase
        end
    end

    assign busy       = (state == CLEAR);
    // Reset freezes the array, so the sweep write is suppressed while it is held.
    assign clear_we   = busy && !reset;
    assign clear_addr = ptr;

endmodule

// File: rtl/my_ram_n.sv
// Single-port word store with combinational read and a full-array zero sweep
// triggered by reset or clr; reads return 0 while the sweep runs.
module my_ram_n
    import my_ram_pkg::*;
#(
    parameter  int WIDTH  = DEFAULT_WIDTH,
    parameter  int DEPTH  = DEFAULT_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  in,
    input  logic [ADDR_W-1:0] addr,
    input  logic              load,
    input  logic              clr,
    output logic [WIDTH-1:0]  out,
    output logic              busy
);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic              clear_we;
    logic [ADDR_W-1:0] clear_addr;
    logic              user_we;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;

    my_ram_clear_fsm #(
        .DEPTH(DEPTH)
    ) u_clear_fsm (
        .clk        (clk),
        .reset      (reset),
        .clr        (clr),
        .busy       (busy),
        .clear_we   (clear_we),
        .clear_addr (clear_addr)
    );

    // A clr in the same cycle wins over load, and nothing is written while busy.
    assign user_we = !busy && load && !clr && !reset;

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = addr;
        wr_data = in;
        if (clear_we) begin
            wr_en   = 1'b1;
            wr_addr = clear_addr;
            wr_data = '0;
        end else if (user_we) begin
            wr_en = 1'b1;
        end
    end

    // NOTE: the array has no reset branch; it is zeroed by the sweep instead,
    // which keeps it mappable onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign out = busy ? '0 : mem[addr];

endmodule

// File: tb/tb_my_ram_n.sv
// Scoreboard bench for my_ram_n: a 16x64 and a 4x8 instance driven by directed
// and random stimulus, checked against a word-array model of the RAM.
module tb_my_ram_n;

    typedef struct {
        int          cyc;
        int          sel;
        logic [15:0] out;
        logic        busy;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_a, load_a, clr_a, busy_a;
    logic [15:0] in_a, out_a;
    logic [5:0]  addr_a;
    logic        reset_b, load_b, clr_b, busy_b;
    logic [3:0]  in_b, out_b;
    logic [2:0]  addr_b;

    my_ram_n #(.WIDTH(16), .DEPTH(64)) dut_a (
        .clk(clk), .reset(reset_a), .in(in_a), .addr(addr_a),
        .load(load_a), .clr(clr_a), .out(out_a), .busy(busy_a)
    );

    my_ram_n #(.WIDTH(4), .DEPTH(8)) dut_b (
        .clk(clk), .reset(reset_b), .in(in_b), .addr(addr_b),
        .load(load_b), .clr(clr_b), .out(out_b), .busy(busy_b)
    );

    // Reference model: word contents, whether a sweep is pending, and how many
    // words of the current sweep are already zeroed.
    int unsigned m_mem [2][64];
    bit          m_busy [2];
    int          m_done [2];
    int          depth_of [2] = '{64, 8};
    int unsigned mask_of  [2] = '{32'hFFFF, 32'hF};

    exp_t sb[$];
    int   cycle    = 0;
    int   n_checks = 0;
    int   n_fails  = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic model_edge(input int s, input bit rst, input bit ld, input bit cl,
                              input int a, input int unsigned d);
        if (rst) begin
            m_busy[s] = 1'b1;
            m_done[s] = 0;
        end else if (m_busy[s]) begin
            m_mem[s][m_done[s]] = 0;
            m_done[s]++;
            if (m_done[s] == depth_of[s]) begin
                m_busy[s] = 1'b0;
                m_done[s] = 0;
            end
        end else if (cl) begin
            m_busy[s] = 1'b1;
            m_done[s] = 0;
        end else if (ld) begin
            m_mem[s][a] = d;
        end
    endtask

    // One clock edge on instance s; the other instance sees idle inputs.
    task automatic step(input int s, input bit rst, input bit ld, input bit cl,
                        input int a, input int unsigned d, input string name);
        int          am;
        int unsigned dm;
        exp_t        e;
        am = a % depth_of[s];
        dm = d & mask_of[s];
        reset_a = 1'b0; load_a = 1'b0; clr_a = 1'b0; addr_a = '0; in_a = '0;
        reset_b = 1'b0; load_b = 1'b0; clr_b = 1'b0; addr_b = '0; in_b = '0;
        if (s == 0) begin
            reset_a = rst; load_a = ld; clr_a = cl; addr_a = 6'(am); in_a = 16'(dm);
        end else begin
            reset_b = rst; load_b = ld; clr_b = cl; addr_b = 3'(am); in_b = 4'(dm);
        end
        e.cyc  = cycle;
        e.sel  = s;
        e.busy = m_busy[s];
        e.out  = m_busy[s] ? 16'h0 : 16'(m_mem[s][am]);
        e.name = name;
        sb.push_back(e);
        @(posedge clk);
        model_edge(s, rst, ld, cl, am, dm);
        model_edge(1 - s, 1'b0, 1'b0, 1'b0, 0, 0);
        cycle++;
        #1;
    endtask

    always @(negedge clk) begin
        exp_t        e;
        logic [15:0] act_out;
        logic        act_busy;
        while (sb.size() > 0 && sb[0].cyc <= cycle) begin
            e = sb.pop_front();
            act_out  = (e.sel == 0) ? out_a  : {12'h0, out_b};
            act_busy = (e.sel == 0) ? busy_a : busy_b;
            check({e.name, " out"},  act_out, e.out);
            check({e.name, " busy"}, {15'h0, act_busy}, {15'h0, e.busy});
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cycle);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_a = 1'b1; load_a = 1'b0; clr_a = 1'b0; addr_a = '0; in_a = '0;
        reset_b = 1'b1; load_b = 1'b0; clr_b = 1'b0; addr_b = '0; in_b = '0;
        @(posedge clk);
        model_edge(0, 1'b1, 1'b0, 1'b0, 0, 0);
        model_edge(1, 1'b1, 1'b0, 1'b0, 0, 0);
        cycle++;
        #1;

        // Basic reset: 64 busy edges, then every word reads 0.
        for (int i = 0; i < 64; i++) step(0, 0, 0, 0, $urandom_range(0, 63), 0, "reset_sweep");
        for (int i = 0; i < 64; i++) step(0, 0, 0, 0, i, 0, "post_reset_read");

        // Write/readback.
        begin
            int wa [8] = '{0, 1, 2, 19, 12, 21, 6, 39};
            for (int i = 0; i < 8; i++) step(0, 0, 1, 0, wa[i], i + 2, "write");
            for (int i = 0; i < 8; i++) step(0, 0, 0, 0, wa[i], 0, "readback");
        end

        // Write attempted on sweep edge 10 must be dropped.
        step(0, 0, 0, 1, 5, 0, "clr_start");
        for (int i = 1; i <= 64; i++)
            step(0, 0, (i == 10), 0, 5, 32'hBEEF, "busy_write");
        step(0, 0, 0, 0, 5, 0, "busy_write_read");

        // clr and load colliding on the same edge.
        step(0, 0, 1, 0, 3, 7, "pre_collide_write");
        step(0, 0, 0, 0, 3, 0, "pre_collide_read");
        step(0, 0, 1, 1, 3, 9, "collide");
        for (int i = 0; i < 64; i++) step(0, 0, 0, 0, 3, 0, "collide_sweep");
        step(0, 0, 0, 0, 3, 0, "collide_read3");
        step(0, 0, 0, 0, 0, 0, "collide_read0");

        // Reset pulse on sweep edge 30 restarts the sweep.
        step(0, 0, 1, 0, 17, 32'h1234, "pre_mid_write");
        step(0, 0, 0, 1, 0, 0, "mid_clr");
        for (int i = 1; i < 30; i++) step(0, 0, 0, 0, 17, 0, "mid_sweep");
        step(0, 1, 0, 0, 17, 0, "mid_reset");
        for (int i = 0; i < 64; i++) step(0, 0, 0, 0, 17, 0, "restart_sweep");
        step(0, 0, 0, 0, 17, 0, "restart_done");

        // Random traffic on the large instance.
        for (int i = 0; i < 400; i++)
            step(0, ($urandom_range(0, 199) == 0), $urandom_range(0, 1),
                 ($urandom_range(0, 39) == 0), $urandom_range(0, 63), $urandom, "rand_a");

        // Small instance: 8-edge sweep, boundary addresses.
        step(1, 1, 0, 0, 0, 0, "small_reset");
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0, i, 0, "small_sweep");
        step(1, 0, 1, 0, 7, 32'hF, "small_write7");
        step(1, 0, 1, 0, 0, 32'h1, "small_write0");
        step(1, 0, 0, 0, 7, 0, "small_read7");
        step(1, 0, 0, 0, 0, 0, "small_read0");
        for (int i = 0; i < 200; i++)
            step(1, ($urandom_range(0, 99) == 0), $urandom_range(0, 1),
                 ($urandom_range(0, 19) == 0), $urandom_range(0, 7), $urandom, "rand_b");

        @(negedge clk);
        check("scoreboard_drained", 16'(sb.size()), 16'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/my_ram_n.md
MY_RAM_N -- requirements
Module: my_ram_n

Interface
REQ-001 The block SHALL take parameter WIDTH, default 16, as the data word width in bits.
REQ-002 The block SHALL take parameter DEPTH, default 64, as the number of words (power of two, minimum 2).
REQ-003 The block SHALL derive local parameter ADDR_W = clog2(DEPTH), default 6, as the address width.
REQ-004 The block SHALL have port clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-005 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have port in  input  WIDTH  write data.
REQ-007 The block SHALL have port addr  input  ADDR_W  read/write address.
REQ-008 The block SHALL have port load  input  1  write enable.
REQ-009 The block SHALL have port clr  input  1  request a full-array zero sweep.
REQ-010 The block SHALL have port out  output  WIDTH  read data.
REQ-011 The block SHALL have port busy  output  1  high while a clear sweep is in progress.

Function
REQ-012 The block SHALL hold the sweep FSM in one of two states: IDLE or CLEAR. busy SHALL equal (state == CLEAR), taken from a register.
REQ-013 In IDLE, out SHALL be the combinational read of the word at addr. In CLEAR, out SHALL be forced to 0.
REQ-014 In IDLE, a rising edge with load=1, clr=0 and reset=0 SHALL write in to word addr. out SHALL show the new value after that edge and the old value before it.
REQ-015 In IDLE, a rising edge with clr=1 and reset=0 SHALL enter CLEAR with sweep pointer 0. Any load in the same cycle SHALL be discarded.
REQ-016 In CLEAR, each rising edge with reset=0 SHALL write 0 to word ptr and then increment ptr.
REQ-017 When the edge clears word DEPTH-1, the FSM SHALL return to IDLE. A sweep therefore lasts exactly DEPTH edges, and ptr SHALL wrap to 0.
REQ-018 In CLEAR, load and clr SHALL be ignored: no user writes and no sweep restart.
REQ-019 The in and addr inputs SHALL never alter array contents except through REQ-014.

Reset
REQ-020 A rising edge with reset=1 SHALL set state to CLEAR and ptr to 0, which sets busy=1 and out=0. reset SHALL take priority over load, clr and any sweep write.
REQ-021 While reset is held, the array SHALL NOT be written and ptr SHALL stay at 0.
REQ-022 After reset is released, the sweep of REQ-016 and REQ-017 SHALL run, so busy falls after DEPTH further edges.
REQ-023 Asserting reset mid-sweep SHALL restart the sweep from word 0.
REQ-024 After reset plus sweep, every word SHALL read 0. No array contents SHALL be guaranteed before the first reset.

Structure
REQ-025 Package my_ram_pkg SHALL hold the state enum (IDLE, CLEAR) and the default WIDTH and DEPTH constants.
REQ-026 The sweep FSM and pointer SHALL live in one sub-module, my_ram_clear_fsm. It SHALL take DEPTH as a parameter and drive busy, the clear-write enable and the clear address.
REQ-027 The storage array, the write-port mux (user write vs. clear write) and the out gating SHALL live in my_ram_n.

Verification
REQ-028 The bench SHALL cover basic reset: WIDTH=16, DEPTH=64, reset high for 1 edge then low. busy=1 and out=0 for exactly 64 edges, then busy=0, and all 64 addresses read 0.
REQ-029 The bench SHALL cover write/readback: after reset, write 2..9 to addresses 0, 1, 2, 19, 12, 21, 6, 39. With load=0, reading those addresses returns 2..9 in order.
REQ-030 The bench SHALL cover a write while busy: load=1, addr=5, in=16'hBEEF on sweep edge 10. After the sweep, addr 5 reads 0.
REQ-031 The bench SHALL cover clr and load colliding: addr 3 holds 7, then one edge with clr=1, load=1, in=9, addr=3. busy rises, out=0 for 64 edges, then addr 3 reads 0 and addr 0 reads 0.
REQ-032 The bench SHALL cover reset mid-sweep: reset pulsed for 1 edge on sweep edge 30. busy stays high for 64 edges after the pulse, with no early drop.
REQ-033 The bench SHALL cover a small instance: WIDTH=4, DEPTH=8 (ADDR_W=3). The sweep takes 8 edges; writing 4'hF to addr 7 and 4'h1 to addr 0 reads back 4'hF and 4'h1.
